led_mode_sequencer: RTL and testbench

- Controller that sequences the four LED pattern modes and the four-step display speed of the LED pattern datapath.
- Generates mode_sel and freq_sel for the pattern top level.
- Changes mode on a manual request, or automatically after a dwell time.
- Every mode change is preceded by a blanking interval. During it, pattern_rst holds the pattern generators in reset, so each new pattern starts from its initial frame.

---
 rtl/led_mode_sequencer_pkg.sv | 25 ++
 rtl/led_mode_sequencer_if.sv | 23 ++
 rtl/led_dwell_timer.sv | 39 +++
 rtl/led_mode_sequencer.sv | 112 +++++++++++
 tb/tb_led_mode_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_mode_sequencer_pkg.sv
// rtl/led_mode_sequencer_pkg.sv - shared state, mode and speed definitions for the LED sequencer
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BLANK = 2'd1,
        LOAD  = 2'd2
    } seq_state_e;

    localparam logic [1:0] MODE_BLINK = 2'd0;
    localparam logic [1:0] MODE_FILL  = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;
    localparam logic [1:0] MODE_ACCUM = 2'd3;

    localparam logic [1:0] FREQ_0 = 2'd0;
    localparam logic [1:0] FREQ_1 = 2'd1;
    localparam logic [1:0] FREQ_2 = 2'd2;
    localparam logic [1:0] FREQ_3 = 2'd3;

    // Both the mode and speed selects step forward modulo four.
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// rtl/led_mode_sequencer_if.sv - request and select signals between a requester and the sequencer
interface led_mode_sequencer_if;

    logic       tick;
    logic       next_req;
    logic       auto_en;
    logic       speed_req;
    logic [1:0] mode_sel;
    logic [1:0] freq_sel;
    logic       pattern_rst;
    logic       blank;

    modport master (
        output tick, next_req, auto_en, speed_req,
        input  mode_sel, freq_sel, pattern_rst, blank
    );

    modport slave (
        input  tick, next_req, auto_en, speed_req,
        output mode_sel, freq_sel, pattern_rst, blank
    );

endinterface

// File: rtl/led_dwell_timer.sv
// rtl/led_dwell_timer.sv - tick counter with enable, clear and terminal-count strobe
module led_dwell_timer #(
    parameter int TERMINAL = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tc_o only fires on the enabled count that reaches the terminal value.
    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - sequences LED pattern modes with a blanking interval and steps the speed select
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int DWELL_TICKS  = 16,
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    led_mode_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0]       freq_q, freq_d;
    logic             prst_q, prst_d;
    logic             blank_q, blank_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    logic in_run;
    logic dwell_en;
    logic dwell_clr;
    logic expire;
    logic trigger;

    assign in_run    = (state_q == RUN);
    assign dwell_en  = in_run && bus.auto_en && bus.tick;
    // Dwell restarts from zero outside RUN, with auto off, and on any manual advance.
    assign dwell_clr = !in_run || !bus.auto_en || bus.next_req;
    assign trigger   = in_run && (bus.next_req || expire);

    led_dwell_timer #(
        .TERMINAL (DWELL_TICKS),
        .CNT_W    (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .en_i  (dwell_en),
        .clr_i (dwell_clr),
        .tc_o  (expire)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        prst_d    = prst_q;
        blank_d   = blank_q;
        bcnt_d    = bcnt_q;
        freq_d    = bus.speed_req ? next_sel(freq_q) : freq_q;

        case (state_q)
            RUN: begin
                if (trigger) begin
                    state_d   = BLANK;
                    pending_d = next_sel(mode_q);
                    bcnt_d    = '0;
                    prst_d    = 1'b1;
                    blank_d   = 1'b1;
                end
            end
            BLANK: begin
                bcnt_d = bcnt_q + ONE;
                if (bcnt_q == BLANK_LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mode_d  = pending_q;
                prst_d  = 1'b0;
                blank_d = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                prst_d  = 1'b0;
                blank_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            mode_q    <= MODE_BLINK;
            pending_q <= MODE_BLINK;
            freq_q    <= FREQ_0;
            prst_q    <= 1'b0;
            blank_q   <= 1'b0;
            bcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            freq_q    <= freq_d;
            prst_q    <= prst_d;
            blank_q   <= blank_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign bus.mode_sel    = mode_q;
    assign bus.freq_sel    = freq_q;
    assign bus.pattern_rst = prst_q;
    assign bus.blank       = blank_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - directed self-checking bench for led_mode_sequencer
module tb_led_mode_sequencer;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;

    led_mode_sequencer_if bus ();

    led_mode_sequencer #(
        .DWELL_TICKS  (3),
        .BLANK_CYCLES (4),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset         = 1'b0;
        bus.tick      = 1'b0;
        bus.next_req  = 1'b0;
        bus.auto_en   = 1'b0;
        bus.speed_req = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank} !== 6'b0)
            $display("FAIL reset_held: got %b want 000000", {bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank});
        else pass_cnt++;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank} !== 6'b0)
                $display("FAIL reset_idle[%0d]: got %b want 000000", i, {bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank});
            else pass_cnt++;
        end
    endtask

    task automatic test_next_seq();
        logic [1:0] exp_seq [4];
        logic [1:0] prev;
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        prev = 2'd0;
        for (int i = 0; i < 4; i++) begin
            bus.next_req = 1'b1;
            @(negedge clk);
            bus.next_req = 1'b0;
            for (int j = 0; j < 5; j++) begin
                chk_cnt++;
                if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== {2'b11, prev})
                    $display("FAIL next_blank[%0d][%0d]: got %b want %b", i, j, {bus.pattern_rst, bus.blank, bus.mode_sel}, {2'b11, prev});
                else pass_cnt++;
                @(negedge clk);
            end
            chk_cnt++;
            if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== {2'b00, exp_seq[i]})
                $display("FAIL next_mode[%0d]: got %b want %b", i, {bus.pattern_rst, bus.blank, bus.mode_sel}, {2'b00, exp_seq[i]});
            else pass_cnt++;
            prev = exp_seq[i];
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_auto();
        bus.auto_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            logic [1:0] old_m;
            logic [1:0] new_m;
            old_m = 2'(r);
            new_m = 2'(r + 1);
            for (int t = 1; t <= 3; t++) begin
                repeat (7) @(negedge clk);
                bus.tick     = 1'b1;
                bus.next_req = (r == 0) && (t == 3);
                @(negedge clk);
                bus.tick     = 1'b0;
                bus.next_req = 1'b0;
                if (t < 3) begin
                    chk_cnt++;
                    if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== {2'b00, old_m})
                        $display("FAIL auto_early[%0d][%0d]: got %b want %b", r, t, {bus.pattern_rst, bus.blank, bus.mode_sel}, {2'b00, old_m});
                    else pass_cnt++;
                end
            end
            for (int j = 0; j < 5; j++) begin
                chk_cnt++;
                if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== {2'b11, old_m})
                    $display("FAIL auto_blank[%0d][%0d]: got %b want %b", r, j, {bus.pattern_rst, bus.blank, bus.mode_sel}, {2'b11, old_m});
                else pass_cnt++;
                @(negedge clk);
            end
            chk_cnt++;
            if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== {2'b00, new_m})
                $display("FAIL auto_mode[%0d]: got %b want %b", r, {bus.pattern_rst, bus.blank, bus.mode_sel}, {2'b00, new_m});
            else pass_cnt++;
        end
        bus.auto_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_next_in_blank();
        bus.next_req = 1'b1;
        @(negedge clk);
        bus.next_req = 1'b0;
        for (int j = 0; j < 15; j++) begin
            logic [3:0] want;
            want = (j < 5) ? 4'b1110 : 4'b0011;
            chk_cnt++;
            if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== want)
                $display("FAIL drop_req[%0d]: got %b want %b", j, {bus.pattern_rst, bus.blank, bus.mode_sel}, want);
            else pass_cnt++;
            bus.next_req = (j == 1) || (j == 4);
            @(negedge clk);
        end
        bus.next_req = 1'b0;
        bus.next_req = 1'b1;
        @(negedge clk);
        bus.next_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk_cnt++;
            if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== 4'b1111)
                $display("FAIL resume_blank[%0d]: got %b want 1111", j, {bus.pattern_rst, bus.blank, bus.mode_sel});
            else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if ({bus.pattern_rst, bus.blank, bus.mode_sel} !== 4'b0000)
            $display("FAIL resume_mode: got %b want 0000", {bus.pattern_rst, bus.blank, bus.mode_sel});
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_speed();
        bus.speed_req = 1'b1;
        @(negedge clk);
        bus.speed_req = 1'b0;
        chk_cnt++;
        if (bus.freq_sel !== 2'd1)
            $display("FAIL speed_run: got %0d want 1", bus.freq_sel);
        else pass_cnt++;
        @(negedge clk);
        bus.next_req  = 1'b1;
        bus.speed_req = 1'b1;
        @(negedge clk);
        bus.next_req  = 1'b0;
        bus.speed_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            logic [1:0] want_f;
            want_f = (j <= 1) ? 2'd2 : 2'd3;
            chk_cnt++;
            if ({bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel} !== {2'b11, 2'd0, want_f})
                $display("FAIL speed_blank[%0d]: got %b want %b", j, {bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel}, {2'b11, 2'd0, want_f});
            else pass_cnt++;
            bus.speed_req = (j == 1);
            @(negedge clk);
        end
        bus.speed_req = 1'b0;
        chk_cnt++;
        if ({bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel} !== {2'b00, 2'd1, 2'd3})
            $display("FAIL speed_switch_done: got %b want %b", {bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel}, {2'b00, 2'd1, 2'd3});
        else pass_cnt++;
        bus.speed_req = 1'b1;
        @(negedge clk);
        bus.speed_req = 1'b0;
        chk_cnt++;
        if (bus.freq_sel !== 2'd0)
            $display("FAIL speed_wrap: got %0d want 0", bus.freq_sel);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_switch();
        bus.speed_req = 1'b1;
        @(negedge clk);
        bus.speed_req = 1'b0;
        bus.next_req  = 1'b1;
        @(negedge clk);
        bus.next_req  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_cnt++;
        if ({bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel} !== {2'b11, 2'd1, 2'd1})
            $display("FAIL mid_before_reset: got %b want %b", {bus.pattern_rst, bus.blank, bus.mode_sel, bus.freq_sel}, {2'b11, 2'd1, 2'd1});
        else pass_cnt++;
        #1 reset = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank} !== 6'b0)
            $display("FAIL mid_async_reset: got %b want 000000", {bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank} !== 6'b0)
                $display("FAIL mid_after_release[%0d]: got %b want 000000", i, {bus.mode_sel, bus.freq_sel, bus.pattern_rst, bus.blank});
            else pass_cnt++;
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_next_seq();
        test_auto();
        test_next_in_blank();
        test_speed();
        test_reset_mid_switch();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
